// File: rtl/key_expand_iter_pkg.sv
// Shared definitions for the iterative AES key expander: key-size modes,
// Nk/Nr lookup, FSM states and the GF(2^8) xtime helper.
package key_expand_iter_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1 (0x11B).
  localparam logic [7:0] XTIME_POLY = 8'h1B;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  function automatic logic [3:0] nk_of(input mode_e m);
    case (m)
      MODE_192: return NK_192;
      MODE_256: return NK_256;
      default:  return NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input mode_e m);
    case (m)
      MODE_192: return NR_192;
      MODE_256: return NR_256;
      default:  return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Reserved modes and key sizes wider than the instance supports fall back to AES-128.
  function automatic mode_e eff_mode(input logic [1:0] m, input int max_nk);
    mode_e mm;
    mm = mode_e'(m);
    if (mm == MODE_RSVD || int'(nk_of(mm)) > max_nk) return MODE_128;
    return mm;
  endfunction

endpackage

// File: rtl/key_expand_iter_if.sv
// Start/key request and round-key stream between a host and the key expander.
interface key_expand_iter_if #(
  parameter int MAX_NK = 8
);
  logic                  start;
  logic                  start_ready;
  logic [1:0]            mode;
  logic [32*MAX_NK-1:0]  key_in;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [127:0]          rk_out;
  logic [3:0]            rk_idx;
  logic                  busy;

  modport master (
    output start, mode, key_in, rk_ready,
    input  start_ready, rk_valid, rk_out, rk_idx, busy
  );

  modport slave (
    input  start, mode, key_in, rk_ready,
    output start_ready, rk_valid, rk_out, rk_idx, busy
  );
endinterface

// File: rtl/key_expand_iter_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module sbox
  import key_expand_iter_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h00;
    acc = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  // Inverse as a^254 (maps 0 to 0), then affine mix with constant 0x63.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or loop, so no latch can be inferred.
    pw  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    y = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES key expander: one schedule word per cycle, grouped into
// 128-bit round keys presented on a valid/ready stream.
module key_expand_iter
  import key_expand_iter_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input logic clk,
  input logic rst,
  key_expand_iter_if.slave bus
);

  localparam int IDX_W = (MAX_NK > 4) ? 3 : 2;

  state_e       state;
  state_e       state_next;
  mode_e        mode_q;
  logic [5:0]   word_cnt;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  logic [31:0]  key_w   [MAX_NK];
  logic [31:0]  win     [MAX_NK];
  logic [31:0]  asm_buf [3];

  logic [3:0]   nk;
  logic [3:0]   nr;
  logic         accept;
  logic         group_done;
  logic         out_taken;
  logic         stall;
  logic         advance;
  logic         last_word;
  logic         in_key;
  logic         rot_step;
  logic         sub_step;
  logic [IDX_W-1:0] tail_idx;
  logic [31:0]  prev;
  logic [31:0]  oldest;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp;
  logic [31:0]  new_word;

  assign nk         = nk_of(mode_q);
  assign nr         = nr_of(mode_q);
  assign accept     = bus.start && (state == ST_IDLE);
  assign group_done = (word_cnt[1:0] == 2'd3);
  assign out_taken  = rk_valid && bus.rk_ready;
  // Only a completing group needs the output register; other words keep flowing.
  assign stall      = group_done && rk_valid && !bus.rk_ready;
  assign advance    = (state == ST_RUN) && !stall;
  assign last_word  = (word_cnt == {nr, 2'b11});

  // Word generation: key words first, then w[i-Nk] ^ temp.
  assign in_key   = (word_cnt < {2'b00, nk});
  assign rot_step = (pos == 3'd0);
  assign sub_step = (nk == NK_256) && (pos == 3'd4);
  assign tail_idx = IDX_W'(nk - 4'd1);
  assign prev     = win[0];
  assign oldest   = win[tail_idx];
  assign sub_in   = rot_step ? {prev[7:0], prev[31:8]} : prev;
  assign temp     = rot_step ? (sub_out ^ {24'h0, rcon}) :
                    sub_step ? sub_out : prev;
  assign new_word = in_key ? key_w[word_cnt[IDX_W-1:0]] : (oldest ^ temp);

  // One S-box per byte on the single SubWord path used by both SubWord cases.
  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: IDLE -> RUN on start, RUN -> DRAIN after the last word, DRAIN -> IDLE on final accept.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)               state_next = ST_RUN;
      ST_RUN:   if (advance && last_word) state_next = ST_DRAIN;
      ST_DRAIN: if (out_taken)            state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // Control: counters, rcon and the round-key output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_128;
      word_cnt <= 6'd0;
      pos      <= 3'd0;
      rcon     <= RCON_INIT;
      rk_valid <= 1'b0;
      rk_out   <= 128'h0;
      rk_idx   <= 4'd0;
    end else begin
      if (accept) begin
        mode_q   <= eff_mode(bus.mode, MAX_NK);
        word_cnt <= 6'd0;
        pos      <= 3'd0;
        rcon     <= RCON_INIT;
      end else if (advance) begin
        word_cnt <= word_cnt + 6'd1;
        pos      <= ({1'b0, pos} == nk - 4'd1) ? 3'd0 : pos + 3'd1;
        if (!in_key && rot_step) rcon <= xtime(rcon);
      end

      if (advance && group_done) begin
        rk_valid <= 1'b1;
        rk_out   <= {new_word, asm_buf[2], asm_buf[1], asm_buf[0]};
        rk_idx   <= word_cnt[5:2];
      end else if (out_taken) begin
        rk_valid <= 1'b0;
      end
    end
  end

  // Datapath storage: captured key, Nk-deep word window and group assembly buffer.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are left unreset; every entry is written before it is read in a run.
    if (accept) begin
      for (int k = 0; k < MAX_NK; k++) key_w[k] <= bus.key_in[32*k +: 32];
    end
    if (advance) begin
      win[0] <= new_word;
      for (int j = 1; j < MAX_NK; j++) win[j] <= win[j-1];
      if (!group_done) asm_buf[word_cnt[1:0]] <= new_word;
    end
  end

  assign bus.start_ready = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.rk_valid    = rk_valid;
  assign bus.rk_out      = rk_out;
  assign bus.rk_idx      = rk_idx;

endmodule

// File: tb/tb_key_expand_iter.sv
// Self-checking bench for key_expand_iter: FIPS-197 vectors plus random keys,
// random back-pressure, busy-start injection and reset abort.
module tb_key_expand_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_expand_iter_if #(.MAX_NK(8)) bus ();

  key_expand_iter #(.MAX_NK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [2047:0] sbox_bits = SBOX_TAB;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Behavioural model state and compare-process bookkeeping.
  logic [127:0] exp_rk [15];
  int           exp_nr;
  int           exp_idx;
  bit           checking     = 1'b0;
  bit           done         = 1'b0;
  bit           timing_on    = 1'b0;
  bit           hold_pending = 1'b0;
  logic [127:0] held_out;
  logic [3:0]   held_idx;
  logic [127:0] last_rk;
  int           accept_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_bits[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sb(t[8*b +: 8]);
    return r;
  endfunction

  // FIPS-197 byte string (byte 0 written first) to bus order (byte 0 at [7:0]).
  function automatic logic [255:0] from_fips(input logic [255:0] x, input int nbytes);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) r[8*k +: 8] = x[8*(nbytes-1-k) +: 8];
    return r;
  endfunction

  // FIPS-197 KeyExpansion over bytes; fills exp_rk[0..Nr].
  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int rc;
    rc     = 1;
    exp_nr = nk + 6;
    for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub_word({t[7:0], t[31:8]});
          t[7:0] = t[7:0] ^ rc[7:0];
          rc = rc * 2;
          if (rc > 255) rc = rc ^ 'h11b;
        end else if (nk == 8 && i % 8 == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  // Compare process: stall stability and every accepted round key against the model.
  always @(negedge clk) begin
    if (!rst) check("ready_vs_busy", bus.start_ready, !bus.busy);
    if (checking) begin
      check("busy_in_run", bus.busy, 1'b1);
      if (hold_pending)
        check("stall_hold", {bus.rk_valid, bus.rk_idx, bus.rk_out}, {1'b1, held_idx, held_out});
      hold_pending = bus.rk_valid && !bus.rk_ready;
      held_out     = bus.rk_out;
      held_idx     = bus.rk_idx;
      if (bus.rk_valid && bus.rk_ready) begin
        check("rk_idx", bus.rk_idx, exp_idx[3:0]);
        check("rk_out", bus.rk_out, exp_rk[exp_idx]);
        if (timing_on) check("rk_timing", cyc - accept_cyc, 4 * (exp_idx + 1));
        last_rk = bus.rk_out;
        exp_idx++;
        if (exp_idx > exp_nr) begin
          done     = 1'b1;
          checking = 1'b0;
        end
      end
    end
  end

  task automatic run_key(input logic [1:0] m, input logic [255:0] k, input bit rnd_ready,
                         input int abort_after, input bit have_lit, input logic [127:0] lit,
                         input string tag);
    int  nk;
    bit  aborted;
    nk      = (m == 2'd1) ? 6 : (m == 2'd2) ? 8 : 4;
    aborted = 1'b0;
    model_expand(nk, k);
    if (have_lit) check({tag, "_model_pin"}, exp_rk[exp_nr], lit);

    for (int t = 0; t < 100 && !bus.start_ready; t++) @(negedge clk);
    check({tag, "_start_ready"}, bus.start_ready, 1'b1);

    exp_idx      = 0;
    done         = 1'b0;
    hold_pending = 1'b0;
    timing_on    = !rnd_ready;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.key_in   = k;
    bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    bus.start  = 1'b0;
    checking   = 1'b1;

    for (int c = 0; ; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (done) break;
      if (abort_after >= 0 && exp_idx > abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (c > 600) begin
        check({tag, "_timeout"}, exp_idx, exp_nr + 1);
        checking = 1'b0;
        break;
      end
      // Inputs wander after acceptance; none of it may disturb the run.
      bus.key_in = {8{$urandom}};
      bus.mode   = 2'($urandom_range(0, 3));
      bus.start  = ($urandom_range(0, 3) == 0);
      if (rnd_ready) bus.rk_ready = ($urandom_range(0, 2) != 0);
    end
    bus.start = 1'b0;

    if (aborted) begin
      rst      = 1'b1;
      checking = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check({tag, "_abort_valid"}, bus.rk_valid, 1'b0);
      check({tag, "_abort_busy"}, bus.busy, 1'b0);
      check({tag, "_abort_idx"}, bus.rk_idx, 4'd0);
      check({tag, "_abort_out"}, bus.rk_out, 128'h0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check({tag, "_abort_quiet"}, {bus.rk_valid, bus.busy}, 2'b00);
      end
    end else begin
      @(negedge clk);
      check({tag, "_end_busy"}, bus.busy, 1'b0);
      check({tag, "_end_valid"}, bus.rk_valid, 1'b0);
      if (have_lit) check({tag, "_final_key"}, last_rk, lit);
    end
  endtask

  logic [255:0] key_a, key_b, key_c, key_d;
  logic [127:0] lit_a, lit_b, lit_c, lit_d;

  initial begin
    bus.start    = 1'b0;
    bus.mode     = 2'd0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;

    key_a = from_fips(256'h000102030405060708090a0b0c0d0e0f, 16);
    key_b = from_fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
    key_c = from_fips(256'h000102030405060708090a0b0c0d0e0f1011121314151617, 24);
    key_d = from_fips(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32);
    lit_a = 128'(from_fips(256'h13111d7fe3944a17f307a78b4d2b30c5, 16));
    lit_b = 128'(from_fips(256'hd014f9a8c9ee2589e13f0cc8b6630ca6, 16));
    lit_c = 128'(from_fips(256'ha4970a331a78dc09c418c271e3a41d5d, 16));
    lit_d = 128'(from_fips(256'h24fc79ccbf0979e9371ac23c6d68de36, 16));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", bus.rk_valid, 1'b0);
    check("reset_out", bus.rk_out, 128'h0);
    check("reset_idx", bus.rk_idx, 4'd0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_start_ready", bus.start_ready, 1'b1);

    run_key(2'd0, key_a, 1'b0, -1, 1'b1, lit_a, "aes128_fips");
    run_key(2'd0, key_b, 1'b1, -1, 1'b1, lit_b, "aes128_bp");
    run_key(2'd1, key_c, 1'b1, -1, 1'b1, lit_c, "aes192_fips");
    run_key(2'd2, key_d, 1'b0, -1, 1'b1, lit_d, "aes256_fips");
    run_key(2'd3, key_a, 1'b1, -1, 1'b1, lit_a, "mode3_as_128");

    for (int r = 0; r < 4; r++)
      run_key(2'($urandom_range(0, 3)), {8{$urandom}}, 1'b1, -1, 1'b0, 128'h0, "random");

    // Abort after round 3 is accepted, then a fresh expansion.
    run_key(2'd0, key_a, 1'b0, 3, 1'b0, 128'h0, "abort");
    run_key(2'd0, key_a, 1'b0, -1, 1'b1, lit_a, "after_abort");

    // Reset wins over start in the same cycle.
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mode   = 2'd0;
    bus.key_in = key_a;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", bus.busy, 1'b0);
    check("rst_prio_ready", bus.start_ready, 1'b1);
    repeat (6) @(negedge clk);
    check("rst_prio_no_key", {bus.rk_valid, bus.busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_expand_iter.md
KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 SHALL provide parameter MAX_NK, default 8, giving the largest supported key length in words (legal values 4, 6, 8).
REQ-002 SHALL provide ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to expand a new key.
- start_ready  out  1  high when a start is accepted.
- mode  in  2  key size: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- key_in  in  32*MAX_NK  cipher key; word k at bits [32k+31:32k]; byte 0 of each word at [7:0].
- rk_valid  out  1  round key presented.
- rk_ready  in  1  consumer accepts round key.
- rk_out  out  128  round key; word 0 at [31:0].
- rk_idx  out  4  round number of rk_out, 0..Nr.
- busy  out  1  expansion in progress.
REQ-003 SHALL sample key_in and mode only on the start-accept edge (start && start_ready); later changes are ignored.

Function
REQ-004 SHALL derive Nk/Nr from the captured mode: 4/10, 6/12, 8/14; modes 3 and any mode with Nk > MAX_NK SHALL behave as mode 0.
REQ-005 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; start_ready = 1 only in IDLE; busy = 1 in RUN and DRAIN.
REQ-006 In RUN SHALL produce one word w[i] per non-stalled cycle, i = 0..4(Nr+1)-1: w[i] = key word i for i < Nk, else w[i-Nk] ^ temp.
REQ-007 temp = SubWord(RotWord(w[i-1])) ^ rcon when i mod Nk == 0; SubWord(w[i-1]) when Nk == 8 and i mod 8 == 4; else w[i-1].
REQ-008 RotWord SHALL give output byte0 = input byte1, byte1 = byte2, byte2 = byte3, byte3 = byte0; rcon SHALL be XORed into bits [7:0].
REQ-009 rcon SHALL be generated internally: 0x01 at start, advanced by GF(2^8) xtime (poly 0x11B) after each use.
REQ-010 SHALL keep an Nk-deep word window plus a 4-word assembly buffer; when the 4th word of a group is generated, {w, buf[2:0]} SHALL load rk_out in the same edge, rk_idx = group number.
REQ-011 First rk_valid SHALL rise 4 cycles after the start-accept edge; with rk_ready held high, one round key every 4 cycles and the last at 4(Nr+1) cycles.
REQ-012 rk_out/rk_idx SHALL hold stable while rk_valid && !rk_ready; generation SHALL stall (window, counters, rcon frozen) only when a group completes and the output register is still occupied and not being accepted in that cycle.
REQ-013 After the last word is generated the FSM SHALL enter DRAIN; on acceptance of round Nr it SHALL return to IDLE; start_ready may rise the following cycle.
REQ-014 start asserted while busy SHALL be ignored with no effect.

Reset
REQ-015 On rst: state IDLE, rk_valid = 0, rk_out = 0, rk_idx = 0, busy = 0, start_ready = 1 in the following cycle, rcon = 0x01, counters = 0.
REQ-016 rst asserted mid-expansion SHALL abort immediately; no further round keys from that key are presented.
REQ-017 rst SHALL take priority over start in the same cycle.

Structure
REQ-018 A shared package SHALL hold mode encodings, Nk/Nr lookup constants, FSM state encoding and the xtime polynomial.
REQ-019 SHALL instantiate the team's existing sbox module four times (one per byte) on a single SubWord path shared by both SubWord cases.
REQ-020 SHALL not instantiate any other sub-module.

Verification
All vectors below are FIPS-197 byte strings, with byte 0 on bus bits [7:0].
REQ-021 mode 0, key 000102..0f, rk_ready = 1 -> 11 keys at 4-cycle spacing; rk_idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-022 mode 0, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready toggled pseudo-randomly -> rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rk_out is stable during every stall.
REQ-023 mode 1, key 000102..17 -> 13 keys; rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d.
REQ-024 mode 2, key 000102..1f -> 15 keys; rk_idx 14 = 24fc79ccbf0979e9371ac23c6d68de36; mode 3 -> identical to mode 0.
REQ-025 rst pulsed after round 3 accepted -> next cycle rk_valid = 0, busy = 0; a fresh start reproduces round 0 correctly; start while busy is ignored.
